// File: rtl/bullet_ctrl.sv
// bullet_ctrl: per-player bullet engine.
// Spawns one bullet on a fire request, advances it once per frame tick,
// resolves shield / squat / hit against the opponent and owns the opponent's
// HP counter. All outputs except o_dead come straight from flops.
module bullet_ctrl #(
  parameter int X_W         = 11,
  parameter int BULLET_STEP = 12,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 1279,
  parameter int SPAWN_OFS   = 40,
  parameter int MUZZLE_DY   = 60,
  parameter int HIT_HALF_W  = 24,
  parameter int HP_W        = 3,
  parameter int HP_INIT     = 5,
  parameter int COOLDOWN    = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_frame_tick,
  input  logic            i_round_restart,
  input  logic            i_fire,
  input  logic            i_dir,
  input  logic [X_W-1:0]  i_shooter_x,
  input  logic [X_W-1:0]  i_shooter_y,
  input  logic [X_W-1:0]  i_target_x,
  input  logic            i_target_shield,
  input  logic            i_target_squat,
  output logic            o_active,
  output logic [X_W-1:0]  o_bullet_x,
  output logic [X_W-1:0]  o_bullet_y,
  output logic            o_hit,
  output logic            o_blocked,
  output logic [HP_W-1:0] o_target_hp,
  output logic            o_dead
);

  // Signed working width: two guard bits cover both the spawn offset beyond
  // the 11-bit range and negative positions off the left edge.
  localparam int SW    = X_W + 2;
  localparam int CNT_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

  localparam logic signed [SW-1:0] STEP_S  = SW'(BULLET_STEP);
  localparam logic signed [SW-1:0] OFS_S   = SW'(SPAWN_OFS);
  localparam logic signed [SW-1:0] XMIN_S  = SW'(X_MIN);
  localparam logic signed [SW-1:0] XMAX_S  = SW'(X_MAX);
  localparam logic signed [SW-1:0] HALF_S  = SW'(HIT_HALF_W);
  localparam logic [X_W-1:0]       MDY_U   = X_W'(MUZZLE_DY);
  localparam logic [X_W-1:0]       XMIN_U  = X_W'(X_MIN);
  localparam logic [X_W-1:0]       XMAX_U  = X_W'(X_MAX);
  localparam logic [HP_W-1:0]      HP_RST  = HP_W'(HP_INIT);
  localparam logic [CNT_W-1:0]     CNT_LD  = CNT_W'(COOLDOWN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_COOL = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [X_W-1:0]    y_q, y_d;
  logic              dir_q, dir_d;
  logic              active_q, active_d;
  logic              hit_q, hit_d;
  logic              blocked_q, blocked_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic                 dead_s;
  logic signed [SW-1:0] shooter_s;
  logic signed [SW-1:0] spawn_raw_s;
  logic [X_W-1:0]       spawn_x_s;
  logic [X_W-1:0]       spawn_y_s;
  logic signed [SW-1:0] nx_s;
  logic signed [SW-1:0] dist_s;
  logic signed [SW-1:0] abs_dist_s;
  logic                 out_of_range_s;
  logic                 in_hit_s;
  logic [HP_W-1:0]      hp_dec_s;

  assign dead_s = (hp_q == {HP_W{1'b0}});

  // Spawn point and next-position geometry, all in signed arithmetic.
  always_comb begin
    shooter_s   = $signed({2'b00, i_shooter_x});
    spawn_raw_s = shooter_s + OFS_S;
    if (i_dir) begin
      spawn_raw_s = shooter_s - OFS_S;
    end else begin
      spawn_raw_s = shooter_s + OFS_S;
    end

    spawn_x_s = spawn_raw_s[X_W-1:0];
    if (spawn_raw_s < XMIN_S) begin
      spawn_x_s = XMIN_U;
    end else if (spawn_raw_s > XMAX_S) begin
      spawn_x_s = XMAX_U;
    end else begin
      spawn_x_s = spawn_raw_s[X_W-1:0];
    end

    spawn_y_s = {X_W{1'b0}};
    if (i_shooter_y >= MDY_U) begin
      spawn_y_s = i_shooter_y - MDY_U;
    end else begin
      spawn_y_s = {X_W{1'b0}};
    end

    nx_s = $signed({2'b00, x_q}) + STEP_S;
    if (dir_q) begin
      nx_s = $signed({2'b00, x_q}) - STEP_S;
    end else begin
      nx_s = $signed({2'b00, x_q}) + STEP_S;
    end

    dist_s     = nx_s - $signed({2'b00, i_target_x});
    abs_dist_s = dist_s;
    if (dist_s < $signed({SW{1'b0}})) begin
      abs_dist_s = -dist_s;
    end else begin
      abs_dist_s = dist_s;
    end

    out_of_range_s = (nx_s < XMIN_S) || (nx_s > XMAX_S);
    in_hit_s       = (abs_dist_s <= HALF_S);

    hp_dec_s = hp_q;
    if (dead_s) begin
      hp_dec_s = hp_q;
    end else begin
      hp_dec_s = hp_q - HP_W'(1'b1);
    end
  end

  // Next-state logic: spawn, flight, collision, cooldown and round restart.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    active_d  = active_q;
    hit_d     = 1'b0;
    blocked_d = 1'b0;
    hp_d      = hp_q;
    pend_d    = pend_q;
    cnt_d     = cnt_q;

    if (i_round_restart) begin
      state_d  = ST_IDLE;
      x_d      = {X_W{1'b0}};
      y_d      = {X_W{1'b0}};
      dir_d    = 1'b0;
      active_d = 1'b0;
      hp_d     = HP_RST;
      pend_d   = 1'b0;
      cnt_d    = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_frame_tick) begin
            if ((pend_q || i_fire) && !dead_s) begin
              state_d  = ST_FLY;
              x_d      = spawn_x_s;
              y_d      = spawn_y_s;
              dir_d    = i_dir;
              active_d = 1'b1;
              pend_d   = 1'b0;
            end else begin
              pend_d = pend_q;
            end
          end else if (i_fire && !dead_s) begin
            pend_d = 1'b1;
          end else begin
            pend_d = pend_q;
          end
        end
        ST_FLY: begin
          if (i_frame_tick) begin
            if (out_of_range_s) begin
              state_d  = ST_COOL;
              active_d = 1'b0;
              cnt_d    = CNT_LD;
            end else if (in_hit_s && !i_target_squat) begin
              // Shield wins over a hit; either way the bullet is consumed.
              if (i_target_shield) begin
                blocked_d = 1'b1;
              end else begin
                hit_d = 1'b1;
                hp_d  = hp_dec_s;
              end
              state_d  = ST_COOL;
              active_d = 1'b0;
              cnt_d    = CNT_LD;
            end else begin
              x_d = nx_s[X_W-1:0];
            end
          end else begin
            x_d = x_q;
          end
        end
        ST_COOL: begin
          if (i_frame_tick) begin
            // A count of 0 or 1 both release on this tick.
            if (cnt_q <= CNT_W'(1'b1)) begin
              state_d = ST_IDLE;
              cnt_d   = {CNT_W{1'b0}};
            end else begin
              cnt_d = cnt_q - CNT_W'(1'b1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          active_d = 1'b0;
          pend_d   = 1'b0;
          cnt_d    = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      x_q       <= {X_W{1'b0}};
      y_q       <= {X_W{1'b0}};
      dir_q     <= 1'b0;
      active_q  <= 1'b0;
      hit_q     <= 1'b0;
      blocked_q <= 1'b0;
      hp_q      <= HP_RST;
      pend_q    <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      active_q  <= active_d;
      hit_q     <= hit_d;
      blocked_q <= blocked_d;
      hp_q      <= hp_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_active    = active_q;
  assign o_bullet_x  = x_q;
  assign o_bullet_y  = y_q;
  assign o_hit       = hit_q;
  assign o_blocked   = blocked_q;
  assign o_target_hp = hp_q;
  assign o_dead      = dead_s;

endmodule

// File: tb/tb_bullet_ctrl.sv
// Bench for bullet_ctrl: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_bullet_ctrl;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic        i_rst, i_frame_tick, i_round_restart, i_fire, i_dir;
  logic        i_target_shield, i_target_squat;
  logic [10:0] i_shooter_x, i_shooter_y, i_target_x;
  logic        o_active, o_hit, o_blocked, o_dead;
  logic [10:0] o_bullet_x, o_bullet_y;
  logic [2:0]  o_target_hp;

  bullet_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_frame_tick(i_frame_tick),
    .i_round_restart(i_round_restart), .i_fire(i_fire), .i_dir(i_dir),
    .i_shooter_x(i_shooter_x), .i_shooter_y(i_shooter_y),
    .i_target_x(i_target_x), .i_target_shield(i_target_shield),
    .i_target_squat(i_target_squat), .o_active(o_active),
    .o_bullet_x(o_bullet_x), .o_bullet_y(o_bullet_y), .o_hit(o_hit),
    .o_blocked(o_blocked), .o_target_hp(o_target_hp), .o_dead(o_dead)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: a bullet is either flying, cooling down for a number
  // of ticks, or absent.
  bit m_fly, m_cooling, m_pend, m_dir, m_hit, m_blk;
  int m_left, m_x, m_y, m_hp;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fly = 0; m_cooling = 0; m_pend = 0; m_dir = 0; m_hit = 0; m_blk = 0;
    m_left = 0; m_x = 0; m_y = 0; m_hp = 5;
  endtask

  task automatic model_step();
    int nx, sx, sy, d;
    bit dead;
    m_hit = 0;
    m_blk = 0;
    dead = (m_hp == 0);
    if (i_round_restart) begin
      model_reset();
    end else if (i_frame_tick) begin
      if (m_fly) begin
        nx = m_dir ? m_x - 12 : m_x + 12;
        d  = nx - int'(i_target_x);
        if (d < 0) d = -d;
        if (nx < 0 || nx > 1279) begin
          m_fly = 0; m_cooling = 1; m_left = 8;
        end else if (d <= 24 && !i_target_squat) begin
          if (i_target_shield) m_blk = 1;
          else begin
            m_hit = 1;
            if (m_hp > 0) m_hp = m_hp - 1;
          end
          m_fly = 0; m_cooling = 1; m_left = 8;
        end else begin
          m_x = nx;
        end
      end else if (m_cooling) begin
        if (m_left <= 1) m_cooling = 0;
        else m_left = m_left - 1;
      end else if ((m_pend || i_fire) && !dead) begin
        sx = i_dir ? int'(i_shooter_x) - 40 : int'(i_shooter_x) + 40;
        if (sx < 0) sx = 0;
        if (sx > 1279) sx = 1279;
        sy = int'(i_shooter_y) - 60;
        if (sy < 0) sy = 0;
        m_x = sx; m_y = sy; m_dir = i_dir; m_fly = 1; m_pend = 0;
      end
    end else if (!m_fly && !m_cooling && i_fire && !dead) begin
      m_pend = 1;
    end
  endtask

  task automatic compare_all();
    chk("active", o_active, m_fly);
    chk("hit", o_hit, m_hit);
    chk("blocked", o_blocked, m_blk);
    chk("hp", o_target_hp, m_hp);
    chk("dead", o_dead, (m_hp == 0));
    if (m_fly) begin
      chk("bullet_x", o_bullet_x, m_x);
      chk("bullet_y", o_bullet_y, m_y);
    end
  endtask

  // One clock: drive fire/tick, advance the model on the edge, compare just after.
  task automatic cyc(input bit f, input bit t);
    i_fire = f;
    i_frame_tick = t;
    @(posedge i_clk);
    model_step();
    #1;
    compare_all();
    @(negedge i_clk);
    i_fire = 1'b0;
    i_frame_tick = 1'b0;
    i_round_restart = 1'b0;
  endtask

  task automatic cool_down();
    for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1);
  endtask

  initial begin
    i_rst = 1'b1; i_frame_tick = 1'b0; i_round_restart = 1'b0; i_fire = 1'b0;
    i_dir = 1'b0; i_target_shield = 1'b0; i_target_squat = 1'b0;
    i_shooter_x = 11'd100; i_shooter_y = 11'd200; i_target_x = 11'd1000;
    model_reset();
    #12;
    chk("rst_active", o_active, 0);
    chk("rst_x", o_bullet_x, 0);
    chk("rst_y", o_bullet_y, 0);
    chk("rst_hp", o_target_hp, 5);
    chk("rst_dead", o_dead, 0);
    chk("rst_hit", o_hit, 0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Spawn at 100+40, then one step.
    cyc(1'b1, 1'b1);
    chk("spawn_active", o_active, 1);
    chk("spawn_x", o_bullet_x, 140);
    chk("spawn_y", o_bullet_y, 140);
    cyc(1'b0, 1'b1);
    chk("step_x", o_bullet_x, 152);

    // Hit at distance exactly 24.
    i_target_x = 11'd200;
    cyc(1'b0, 1'b1);
    chk("pre_hit_x", o_bullet_x, 164);
    cyc(1'b0, 1'b1);
    chk("hit_pulse", o_hit, 1);
    chk("hit_hp", o_target_hp, 4);
    chk("hit_inactive", o_active, 0);
    cyc(1'b0, 1'b0);
    chk("hit_pulse_end", o_hit, 0);
    cool_down();

    // Shield absorbs.
    i_target_shield = 1'b1;
    cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b1);
    chk("blk_pulse", o_blocked, 1);
    chk("blk_hp", o_target_hp, 4);
    cool_down();

    // Squat lets the bullet pass through the target.
    i_target_shield = 1'b0;
    i_target_squat = 1'b1;
    cyc(1'b1, 1'b1);
    repeat (5) cyc(1'b0, 1'b1);
    chk("squat_x", o_bullet_x, 200);
    chk("squat_active", o_active, 1);
    i_round_restart = 1'b1;
    cyc(1'b0, 1'b1);
    chk("restart_hp", o_target_hp, 5);
    chk("restart_active", o_active, 0);
    i_target_squat = 1'b0;

    // Left edge exit and cooldown lockout.
    i_target_x = 11'd600;
    i_shooter_x = 11'd48;
    i_dir = 1'b1;
    cyc(1'b1, 1'b1);
    chk("left_spawn_x", o_bullet_x, 8);
    cyc(1'b0, 1'b1);
    chk("edge_inactive", o_active, 0);
    chk("edge_nohit", o_hit, 0);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 1'b1);
      chk("cool_lockout", o_active, 0);
    end
    cyc(1'b1, 1'b1);
    chk("tick9_spawn", o_active, 1);
    chk("tick9_x", o_bullet_x, 8);
    cyc(1'b0, 1'b1);
    cool_down();

    // Five hits kill the target; dead target blocks new spawns.
    i_dir = 1'b0;
    i_shooter_x = 11'd100;
    i_target_x = 11'd200;
    for (int h = 0; h < 5; h++) begin
      cyc(1'b1, 1'b1);
      repeat (3) cyc(1'b0, 1'b1);
      cool_down();
    end
    chk("dead_hp", o_target_hp, 0);
    chk("dead_flag", o_dead, 1);
    repeat (3) cyc(1'b1, 1'b1);
    chk("dead_nospawn", o_active, 0);
    i_round_restart = 1'b1;
    cyc(1'b0, 1'b0);
    chk("revive_hp", o_target_hp, 5);
    chk("revive_dead", o_dead, 0);

    // Asynchronous reset mid-flight after one hit.
    cyc(1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b1);
    cool_down();
    i_target_x = 11'd1000;
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b1);
    chk("fly_before_rst", o_bullet_x, 152);
    #2 i_rst = 1'b1;
    #1;
    chk("async_active", o_active, 0);
    chk("async_x", o_bullet_x, 0);
    chk("async_hp", o_target_hp, 5);
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b0;

    // Randomized run against the model.
    for (int n = 0; n < 6000; n++) begin
      i_dir           = 1'($urandom_range(0, 1));
      i_shooter_x     = 11'($urandom_range(0, 2047));
      i_shooter_y     = 11'($urandom_range(0, 255));
      i_target_x      = 11'($urandom_range(0, 1279));
      i_target_shield = ($urandom_range(0, 3) == 0);
      i_target_squat  = ($urandom_range(0, 3) == 0);
      i_round_restart = ($urandom_range(0, 299) == 0);
      cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
